// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned per operation,
// with divide-by-zero and signed-overflow flags and a start/busy/done handshake.
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinish
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH:0]   rem_q;
    logic [CntW-1:0]  cnt_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             dbz_q;
    logic             ovf_q;

    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;
    logic             a_most_neg;
    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        sa         = is_signed & a[WIDTH-1];
        sb         = is_signed & b[WIDTH-1];
        // The WIDTH-bit negation of the most negative value is its correct unsigned magnitude.
        a_mag      = sa ? (~a + 1'b1) : a;
        b_mag      = sb ? (~b + 1'b1) : b;
        b_zero     = (b == '0);
        a_most_neg = (a == {1'b1, {(WIDTH - 1){1'b0}}});
        rem_shift  = {rem_q, dvd_q[WIDTH-1]};
        diff       = rem_shift - {2'b00, dvs_q};
        quo_fix    = q_neg_q ? (~quo_q + 1'b1) : quo_q;
        rem_fix    = r_neg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        dvd_q   <= b_zero ? a : a_mag;
                        dvs_q   <= b_mag;
                        quo_q   <= '0;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        q_neg_q <= sa ^ sb;
                        r_neg_q <= sa;
                        dbz_q   <= b_zero;
                        ovf_q   <= is_signed && a_most_neg && (&b);
                        busy    <= 1'b1;
                        state_q <= b_zero ? StFinish : StRun;
                    end
                end
                StRun: begin
                    if (!diff[WIDTH+1]) begin
                        rem_q <= diff[WIDTH:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_shift[WIDTH:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                    dvd_q <= dvd_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    quotient    <= dbz_q ? '1 : quo_fix;
                    remainder   <= dbz_q ? dvd_q : rem_fix;
                    div_by_zero <= dbz_q;
                    overflow    <= ovf_q;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: three instances (WIDTH 8, 4, 16) checked against an arithmetic
// reference model with directed handshake cases, exhaustive WIDTH=4 and random WIDTH=8/16.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  st;
    logic        sgn;
    logic [15:0] a_bus;
    logic [15:0] b_bus;

    always #5 clk = ~clk;

    logic       busy8, done8, dz8, ov8;
    logic [7:0] q8, r8;
    logic       busy4, done4, dz4, ov4;
    logic [3:0] q4, r4;
    logic        busy16, done16, dz16, ov16;
    logic [15:0] q16, r16;

    seq_divider #(.WIDTH(8)) u_div8 (
        .clk(clk), .rst(rst), .start(st[0]), .is_signed(sgn), .a(a_bus[7:0]), .b(b_bus[7:0]),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dz8),
        .overflow(ov8)
    );

    seq_divider #(.WIDTH(4)) u_div4 (
        .clk(clk), .rst(rst), .start(st[1]), .is_signed(sgn), .a(a_bus[3:0]), .b(b_bus[3:0]),
        .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(dz4),
        .overflow(ov4)
    );

    seq_divider #(.WIDTH(16)) u_div16 (
        .clk(clk), .rst(rst), .start(st[2]), .is_signed(sgn), .a(a_bus), .b(b_bus),
        .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(dz16),
        .overflow(ov16)
    );

    typedef struct packed {
        logic        done;
        logic        busy;
        logic        dz;
        logic        ov;
        logic [15:0] q;
        logic [15:0] r;
    } snap_t;

    int checks = 0;
    int errors = 0;

    function automatic int wid(int d);
        case (d)
            0:       return 8;
            1:       return 4;
            default: return 16;
        endcase
    endfunction

    function automatic logic [15:0] msk(int w);
        logic [31:0] m;
        m = (32'd1 << w) - 32'd1;
        return m[15:0];
    endfunction

    function automatic snap_t snap(int d);
        snap_t s;
        case (d)
            0:       s = '{done8, busy8, dz8, ov8, 16'(q8), 16'(r8)};
            1:       s = '{done4, busy4, dz4, ov4, 16'(q4), 16'(r4)};
            default: s = '{done16, busy16, dz16, ov16, q16, r16};
        endcase
        return s;
    endfunction

    // Reference: plain integer arithmetic on the operands' numeric values.
    function automatic void ref_div(input int w, input bit sg, input logic [15:0] av,
                                    input logic [15:0] bv, output logic [15:0] q,
                                    output logic [15:0] r, output bit dz, output bit ov);
        longint m;
        longint x;
        longint y;
        longint tq;
        longint tr;
        m  = (longint'(1) << w) - 1;
        dz = 1'b0;
        ov = 1'b0;
        if (bv == 16'd0) begin
            q  = 16'(m);
            r  = av;
            dz = 1'b1;
        end else if (sg) begin
            x = av[w-1] ? longint'(av) - (longint'(1) << w) : longint'(av);
            y = bv[w-1] ? longint'(bv) - (longint'(1) << w) : longint'(bv);
            if (x == -(longint'(1) << (w - 1)) && y == -1) begin
                q  = 16'(longint'(1) << (w - 1));
                r  = 16'd0;
                ov = 1'b1;
            end else begin
                tq = x / y;
                tr = x % y;
                q  = 16'(tq & m);
                r  = 16'(tr & m);
            end
        end else begin
            q = av / bv;
            r = av % bv;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input int d, input bit sg, input logic [15:0] av,
                          input logic [15:0] bv);
        snap_t s;
        @(negedge clk);
        sgn   = sg;
        a_bus = av;
        b_bus = bv;
        st[d] = 1'b1;
        @(negedge clk);
        st[d] = 1'b0;
        s = snap(d);
        chk("busy_after_start", 32'(s.busy), 32'd1);
    endtask

    task automatic wait_done(input int d, input int lat0, output int lat);
        snap_t s;
        lat = lat0;
        s   = snap(d);
        while (!s.done && lat < 100) begin
            @(negedge clk);
            lat++;
            s = snap(d);
        end
    endtask

    task automatic do_check(input int d, input bit sg, input logic [15:0] av,
                            input logic [15:0] bv, input int lat);
        logic [15:0] eq, er;
        bit          edz, eov;
        snap_t       s;
        ref_div(wid(d), sg, av, bv, eq, er, edz, eov);
        s = snap(d);
        chk("done", 32'(s.done), 32'd1);
        chk("latency", 32'(lat), (bv == 16'd0) ? 32'd1 : 32'(wid(d) + 1));
        chk("busy_at_done", 32'(s.busy), 32'd0);
        chk("quotient", 32'(s.q), 32'(eq));
        chk("remainder", 32'(s.r), 32'(er));
        chk("div_by_zero", 32'(s.dz), 32'(edz));
        chk("overflow", 32'(s.ov), 32'(eov));
    endtask

    task automatic run_op(input int d, input bit sg, input logic [15:0] av_in,
                          input logic [15:0] bv_in);
        logic [15:0] av, bv;
        int          lat;
        snap_t       s;
        av = av_in & msk(wid(d));
        bv = bv_in & msk(wid(d));
        launch(d, sg, av, bv);
        wait_done(d, 0, lat);
        do_check(d, sg, av, bv, lat);
        @(negedge clk);
        s = snap(d);
        chk("done_one_cycle", 32'(s.done), 32'd0);
    endtask

    initial begin
        snap_t       s;
        int          lat;
        int          seen;
        logic [15:0] av, bv;
        bit          sg;

        rst   = 1'b1;
        st    = 3'b000;
        sgn   = 1'b0;
        a_bus = 16'd0;
        b_bus = 16'd0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            s = snap(d);
            chk("rst_done", 32'(s.done), 32'd0);
            chk("rst_busy", 32'(s.busy), 32'd0);
            chk("rst_q", 32'(s.q), 32'd0);
            chk("rst_r", 32'(s.r), 32'd0);
            chk("rst_dz", 32'(s.dz), 32'd0);
            chk("rst_ov", 32'(s.ov), 32'd0);
        end
        rst = 1'b0;

        // Directed cases with constant expectations alongside the model.
        run_op(0, 1'b0, 16'd200, 16'd7);
        s = snap(0);
        chk("tp_200_7_q", 32'(s.q), 32'h1C);
        chk("tp_200_7_r", 32'(s.r), 32'd4);
        run_op(0, 1'b1, 16'hF9, 16'h02);
        s = snap(0);
        chk("tp_m7_2_q", 32'(s.q), 32'hFD);
        chk("tp_m7_2_r", 32'(s.r), 32'hFF);
        run_op(0, 1'b1, 16'h07, 16'hFE);
        s = snap(0);
        chk("tp_7_m2_q", 32'(s.q), 32'hFD);
        chk("tp_7_m2_r", 32'(s.r), 32'h01);
        run_op(0, 1'b1, 16'h80, 16'hFF);
        s = snap(0);
        chk("tp_ovf_q", 32'(s.q), 32'h80);
        chk("tp_ovf_flag", 32'(s.ov), 32'd1);
        run_op(0, 1'b0, 16'h80, 16'hFF);
        s = snap(0);
        chk("tp_uns_q", 32'(s.q), 32'h00);
        chk("tp_uns_r", 32'(s.r), 32'h80);
        run_op(0, 1'b0, 16'd13, 16'd0);
        s = snap(0);
        chk("tp_dbz_q", 32'(s.q), 32'hFF);
        chk("tp_dbz_r", 32'(s.r), 32'd13);
        run_op(0, 1'b1, 16'hF3, 16'd0);

        // Start with new operands during RUN must not disturb the operation.
        launch(0, 1'b0, 16'd200, 16'd7);
        repeat (3) @(negedge clk);
        a_bus = 16'd5;
        b_bus = 16'd1;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0, 4, lat);
        do_check(0, 1'b0, 16'd200, 16'd7, lat);

        // Start raised in the done cycle: ignored there, accepted one cycle later.
        a_bus = 16'd50;
        b_bus = 16'd6;
        st[0] = 1'b1;
        @(negedge clk);
        s = snap(0);
        chk("start_in_done_ignored", 32'(s.busy), 32'd0);
        @(negedge clk);
        st[0] = 1'b0;
        s = snap(0);
        chk("start_after_done_accepted", 32'(s.busy), 32'd1);
        wait_done(0, 0, lat);
        do_check(0, 1'b0, 16'd50, 16'd6, lat);
        @(negedge clk);

        // Reset during RUN aborts with no done pulse.
        launch(0, 1'b1, 16'h9C, 16'h05);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        s = snap(0);
        chk("abort_done", 32'(s.done), 32'd0);
        chk("abort_busy", 32'(s.busy), 32'd0);
        chk("abort_q", 32'(s.q), 32'd0);
        chk("abort_r", 32'(s.r), 32'd0);
        rst  = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            s = snap(0);
            if (s.done) seen = 1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        // Exhaustive WIDTH=4, both modes.
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run_op(1, m[0], 16'(x), 16'(y));
                end
            end
        end

        // Random WIDTH=8 and WIDTH=16 with corner operands mixed in.
        for (int d = 0; d < 3; d += 2) begin
            for (int n = 0; n < 60; n++) begin
                sg = 1'($urandom_range(0, 1));
                av = 16'($urandom);
                case ($urandom_range(0, 7))
                    0:       bv = 16'd0;
                    1:       bv = 16'hFFFF;
                    2:       bv = 16'd1;
                    default: bv = 16'($urandom);
                endcase
                if ($urandom_range(0, 7) == 0) av = 16'(32'd1 << (wid(d) - 1));
                run_op(d, sg, av, bv);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative, parametrised integer divider for the FPU datapath, replacing the fixed 4-bit combinational array divider. It produces one quotient bit per clock using restoring shift/subtract, supports unsigned and signed (two's complement) operands selected per operation, and flags divide-by-zero and signed overflow. A start/busy/done handshake lets the FPU microcode sequencer launch an operation and wait for completion.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (legal: 2..32)

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request new division; accepted only when busy=0
- is_signed  in  1  sampled with start: 1 = two's complement operands, 0 = unsigned
- a  in  WIDTH  dividend, sampled with start
- b  in  WIDTH  divisor, sampled with start
- busy  out  1  operation in progress; start ignored while high
- done  out  1  one-cycle pulse, results valid from this cycle
- quotient  out  WIDTH  registered quotient, held until next accepted start
- remainder  out  WIDTH  registered remainder, held until next accepted start
- div_by_zero  out  1  registered, set with done when b = 0
- overflow  out  1  registered, set with done for signed most-negative / -1

## Operation
- States: IDLE, RUN, FINISH. FINISH lasts one cycle, then IDLE.
- IDLE: start=1 -> latch magnitudes |a|, |b| (raw values if is_signed=0), latch sign of quotient (sa XOR sb) and sign of remainder (sa), clear iteration counter, clear div_by_zero/overflow; go RUN. If b=0, go FINISH directly.
- RUN: each cycle, shift partial remainder (WIDTH+1 bits) left by one, bringing in the next dividend MSB; trial-subtract divisor; if result non-negative keep it and shift in quotient bit 1, else restore and shift in 0. Counter runs 0..WIDTH-1; at WIDTH-1 go FINISH.
- FINISH: apply sign correction (negate quotient if quotient sign set, negate remainder if remainder sign set), register quotient/remainder, pulse done, deassert busy.
- Signed semantics: quotient truncates toward zero; remainder takes the sign of the dividend; a = q*b + r always holds (mod 2^WIDTH).
- Divide by zero: quotient = all ones, remainder = a (raw, unmodified), div_by_zero=1, overflow=0, regardless of is_signed.
- Signed overflow (a = most negative, b = -1): quotient = most negative value (wrapped), remainder = 0, overflow=1.
- Internal arithmetic uses WIDTH+1 bits so the unsigned magnitude of the most negative value is representable.
- start while busy=1: ignored, no effect on operation in progress, operands not resampled.
- start in the same cycle as done (FINISH): ignored; accepted from the following IDLE cycle.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, state=IDLE.
- rst dominates start and all state; reset mid-operation aborts silently, no done pulse, outputs return to reset values on the next edge.
- start accepted at edge k: busy=1 after edge k.
- Normal operation: RUN at edges k+1..k+WIDTH, FINISH cycle follows; done=1 and results valid after edge k+WIDTH+1, busy=0 in that same cycle. Latency WIDTH+1 cycles, throughput one op per WIDTH+2 cycles.
- b=0: done=1 after edge k+1 (latency 1).
- done high exactly one cycle; result outputs and flags stable until the edge after the next accepted start, then cleared at that edge? No: flags and results hold until the FINISH of the next operation; only done/busy change in between.

## Test plan
- WIDTH=8, unsigned 200/7 -> after 9 cycles done=1, quotient=28 (0x1C), remainder=4, flags 0.
- Signed -7/2 (0xF9/0x02) -> quotient=0xFD (-3), remainder=0xFF (-1); signed 7/-2 -> quotient=0xFD, remainder=0x01.
- Signed 0x80/0xFF -> quotient=0x80, remainder=0, overflow=1; same operands unsigned (128/255) -> quotient=0, remainder=128, overflow=0.
- 13/0 -> done after 1 cycle, quotient=0xFF, remainder=13, div_by_zero=1.
- Start pulse with new operands at cycle 3 of RUN -> ignored, original result returned; start asserted in done cycle -> ignored, next cycle's start accepted.
- rst asserted during RUN -> next cycle all outputs 0, state IDLE, no done pulse; exhaustive random compare vs. reference model for WIDTH=4 and WIDTH=16, both modes.
